// File: rtl/pcm_mem_arbiter.sv
// pcm_mem_arbiter: round-robin arbiter that serves four CPUs through one PCM memory port,
// one access at a time, and ends each access with a one-cycle ready pulse.
module pcm_mem_arbiter #(
    parameter int          MEM_AW   = 11,
    parameter logic [15:0] OOR_DATA = 16'h0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu0_ce_n,
    input  logic              cpu0_we_n,
    input  logic [19:0]       cpu0_addr,
    input  logic [15:0]       cpu0_wdata,
    output logic              cpu0_ready,
    output logic [15:0]       cpu0_rdata,
    input  logic              cpu1_ce_n,
    input  logic              cpu1_we_n,
    input  logic [19:0]       cpu1_addr,
    input  logic [15:0]       cpu1_wdata,
    output logic              cpu1_ready,
    output logic [15:0]       cpu1_rdata,
    input  logic              cpu2_ce_n,
    input  logic              cpu2_we_n,
    input  logic [19:0]       cpu2_addr,
    input  logic [15:0]       cpu2_wdata,
    output logic              cpu2_ready,
    output logic [15:0]       cpu2_rdata,
    input  logic              cpu3_ce_n,
    input  logic              cpu3_we_n,
    input  logic [19:0]       cpu3_addr,
    input  logic [15:0]       cpu3_wdata,
    output logic              cpu3_ready,
    output logic [15:0]       cpu3_rdata,
    output logic [MEM_AW-1:0] mem_address,
    output logic              mem_chipselect,
    output logic              mem_clken,
    output logic              mem_write,
    output logic [15:0]       mem_writedata,
    output logic [1:0]        mem_byteenable,
    input  logic [15:0]       mem_readdata,
    output logic              oor_err
);
    typedef enum logic [1:0] {IDLE, ISSUE, RDWAIT, DONE} state_t;
    state_t            r_state;
    logic [1:0]        r_p, r_g, w_gnt;
    logic              r_we_n, r_oor, w_oor;
    logic [3:0]        w_req, w_we_n, r_ready;
    logic [19:0]       w_addr [4];
    logic [15:0]       w_wdata [4];
    logic [15:0]       r_rdata [4];
    logic [MEM_AW-1:0] r_mem_addr;
    logic [15:0]       r_mem_wdata;
    logic              r_mem_cs, r_mem_we, r_oor_err;

    assign w_req   = ~{cpu3_ce_n, cpu2_ce_n, cpu1_ce_n, cpu0_ce_n};
    assign w_we_n  = {cpu3_we_n, cpu2_we_n, cpu1_we_n, cpu0_we_n};
    assign w_addr  = '{cpu0_addr, cpu1_addr, cpu2_addr, cpu3_addr};
    assign w_wdata = '{cpu0_wdata, cpu1_wdata, cpu2_wdata, cpu3_wdata};

    // Scan from the farthest slot back to p so the nearest requester after p wins.
    always_comb begin
        w_gnt = r_p;
        for (int k = 3; k >= 0; k--)
            w_gnt = w_req[2'(r_p + 2'(k))] ? 2'(r_p + 2'(k)) : w_gnt;
    end

    assign w_oor = |(w_addr[w_gnt] >> MEM_AW);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_p         <= '0;
            r_g         <= '0;
            r_we_n      <= 1'b1;
            r_oor       <= 1'b0;
            r_ready     <= '0;
            r_rdata     <= '{default: '0};
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_cs    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_oor_err   <= 1'b0;
        end else begin
            r_ready  <= '0;
            r_mem_cs <= 1'b0;
            r_mem_we <= 1'b0;
            case (r_state)
                IDLE: if (|w_req) begin
                    r_g       <= w_gnt;
                    r_we_n    <= w_we_n[w_gnt];
                    r_oor     <= w_oor;
                    r_oor_err <= r_oor_err | w_oor;
                    r_state   <= ISSUE;
                    if (!w_oor) begin
                        r_mem_cs    <= 1'b1;
                        r_mem_we    <= ~w_we_n[w_gnt];
                        r_mem_addr  <= w_addr[w_gnt][MEM_AW-1:0];
                        r_mem_wdata <= w_wdata[w_gnt];
                    end
                end
                ISSUE: begin
                    r_state <= r_we_n ? RDWAIT : DONE;
                    if (!r_we_n) r_ready[r_g] <= 1'b1;
                end
                RDWAIT: begin
                    r_rdata[r_g] <= r_oor ? OOR_DATA : mem_readdata;
                    r_ready[r_g] <= 1'b1;
                    r_state      <= DONE;
                end
                DONE: begin
                    r_p     <= r_g + 2'd1;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign {cpu3_ready, cpu2_ready, cpu1_ready, cpu0_ready} = r_ready;
    assign cpu0_rdata     = r_rdata[0];
    assign cpu1_rdata     = r_rdata[1];
    assign cpu2_rdata     = r_rdata[2];
    assign cpu3_rdata     = r_rdata[3];
    assign mem_address    = r_mem_addr;
    assign mem_chipselect = r_mem_cs;
    assign mem_write      = r_mem_we;
    assign mem_writedata  = r_mem_wdata;
    assign mem_clken      = 1'b1;
    assign mem_byteenable = 2'b11;
    assign oor_err        = r_oor_err;
endmodule

// File: tb/tb_pcm_mem_arbiter.sv
// tb_pcm_mem_arbiter: directed bench with a transaction-level arbiter model and a
// latency-1 registered memory standing in for the PCM port.
module tb_pcm_mem_arbiter;
    logic        clk = 0, reset = 0;
    logic [3:0]  ce_n = 4'hF, we_n = 4'hF, rdy;
    logic [19:0] addr [4];
    logic [15:0] wdata [4];
    logic [15:0] rdata [4];
    logic [10:0] mem_address, last_wr_addr = '0;
    logic        mem_chipselect, mem_clken, mem_write, oor_err;
    logic [15:0] mem_writedata, mem_readdata = '0;
    logic [1:0]  mem_byteenable;
    logic [15:0] mem [2048];
    logic [15:0] m_mem [2048];
    int cyc = 0, n_cmp = 0, n_err = 0, n_wr = 0, n_cs = 0;
    int q_g[$], q_c[$];
    bit m_busy = 0, m_we_n, m_oor, m_oor_err = 0, e_cs, e_wr;
    int m_t0, m_tr, m_free = 0, m_p = 0, m_g, j;
    logic [19:0] m_addr;
    logic [15:0] m_wdata;
    logic [15:0] m_rdata [4];
    logic [3:0]  e_ready;

    pcm_mem_arbiter dut (
        .clk(clk), .reset(reset),
        .cpu0_ce_n(ce_n[0]), .cpu0_we_n(we_n[0]), .cpu0_addr(addr[0]), .cpu0_wdata(wdata[0]),
        .cpu0_ready(rdy[0]), .cpu0_rdata(rdata[0]),
        .cpu1_ce_n(ce_n[1]), .cpu1_we_n(we_n[1]), .cpu1_addr(addr[1]), .cpu1_wdata(wdata[1]),
        .cpu1_ready(rdy[1]), .cpu1_rdata(rdata[1]),
        .cpu2_ce_n(ce_n[2]), .cpu2_we_n(we_n[2]), .cpu2_addr(addr[2]), .cpu2_wdata(wdata[2]),
        .cpu2_ready(rdy[2]), .cpu2_rdata(rdata[2]),
        .cpu3_ce_n(ce_n[3]), .cpu3_we_n(we_n[3]), .cpu3_addr(addr[3]), .cpu3_wdata(wdata[3]),
        .cpu3_ready(rdy[3]), .cpu3_rdata(rdata[3]),
        .mem_address(mem_address), .mem_chipselect(mem_chipselect), .mem_clken(mem_clken),
        .mem_write(mem_write), .mem_writedata(mem_writedata), .mem_byteenable(mem_byteenable),
        .mem_readdata(mem_readdata), .oor_err(oor_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) if (mem_chipselect) begin
        if (mem_write) mem[mem_address] <= mem_writedata;
        mem_readdata <= mem[mem_address];
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rdy != 0) begin
            for (int i = 0; i < 4; i++) if (rdy[i]) q_g.push_back(i);
            q_c.push_back(cyc);
        end
        if (mem_write) begin n_wr++; last_wr_addr = mem_address; end
        if (mem_chipselect) n_cs++;
    end

    // Model: an access sampled at t0 hits memory at t0+1 and completes at t0+2 (write) or t0+3 (read).
    always @(negedge clk) begin
        if (!reset) begin
            m_busy = 0; m_p = 0; m_free = 0; m_oor_err = 0;
            for (int i = 0; i < 4; i++) m_rdata[i] = '0;
        end else if (m_busy) begin
            if (cyc == m_t0 + 1) begin
                if (m_oor) m_oor_err = 1;
                else if (!m_we_n) m_mem[m_addr[10:0]] = m_wdata;
            end
            if (cyc == m_tr && m_we_n) m_rdata[m_g] = m_oor ? 16'h0000 : m_mem[m_addr[10:0]];
        end
        e_ready = (reset && m_busy && cyc == m_tr) ? 4'(1 << m_g) : 4'h0;
        e_cs = reset && m_busy && cyc == m_t0 + 1 && !m_oor;
        e_wr = e_cs && !m_we_n;
        chk("ready", rdy, e_ready);
        chk("chipselect", mem_chipselect, e_cs);
        chk("mem_write", mem_write, e_wr);
        chk("oor_err", oor_err, m_oor_err);
        for (int i = 0; i < 4; i++) chk("rdata", rdata[i], m_rdata[i]);
        if (e_cs) chk("mem_address", mem_address, m_addr[10:0]);
        if (e_wr) chk("mem_writedata", mem_writedata, m_wdata);
        if (e_ready != 0) begin m_busy = 0; m_p = (m_g + 1) % 4; m_free = cyc + 1; end
        if (reset && !m_busy && cyc >= m_free) begin
            for (int k = 0; k < 4; k++) begin
                j = (m_p + k) % 4;
                if (!m_busy && !ce_n[j]) begin
                    m_busy = 1; m_g = j; m_we_n = we_n[j]; m_addr = addr[j]; m_wdata = wdata[j];
                    m_oor = addr[j] >= 20'd2048; m_t0 = cyc; m_tr = cyc + (we_n[j] ? 3 : 2);
                end
            end
        end
    end

    task automatic do_req(input int i, input bit wr, input logic [19:0] a, input logic [15:0] d, output int lat);
        int t0;
        bit got;
        ce_n[i] = 0; we_n[i] = ~wr; addr[i] = a; wdata[i] = d; t0 = cyc; got = 0;
        for (int k = 0; k < 60 && !got; k++) begin
            @(negedge clk);
            if (rdy[i]) got = 1;
        end
        chk("ready_seen", got, 1);
        lat = cyc - t0;
        @(posedge clk); #1;
        ce_n[i] = 1;
    endtask

    task automatic do_reset();
        @(posedge clk); #2 reset = 0;
        repeat (2) @(posedge clk);
        #1 reset = 1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int l0, l1, l2, l3, w0, c0, bad, gap, t0;
        bit got;
        for (int i = 0; i < 2048; i++) begin mem[i] = '0; m_mem[i] = '0; end
        for (int i = 0; i < 4; i++) begin
            mem[16 + i] = 16'h1111 * 16'(i + 1); m_mem[16 + i] = 16'h1111 * 16'(i + 1);
            addr[i] = '0; wdata[i] = '0;
        end
        repeat (3) @(posedge clk); #1;
        chk("rst_ready", rdy, 0);
        chk("rst_cs", mem_chipselect, 0);
        chk("rst_oor", oor_err, 0);
        chk("clken", mem_clken, 1);
        chk("byteen", mem_byteenable, 2'b11);
        reset = 1;
        @(posedge clk); #1;

        w0 = n_wr;
        do_req(0, 1, 20'h00005, 16'hBEEF, l0);
        chk("wr_latency", l0, 2);
        chk("wr_pulses", n_wr - w0, 1);
        chk("wr_addr", last_wr_addr, 11'h005);
        do_req(0, 0, 20'h00005, 16'h0000, l0);
        chk("rd_latency", l0, 3);
        chk("rd_data", rdata[0], 16'hBEEF);

        do_reset();
        q_g.delete(); q_c.delete();
        fork
            do_req(0, 0, 20'h10, 16'h0, l0);
            do_req(1, 0, 20'h11, 16'h0, l1);
            do_req(2, 0, 20'h12, 16'h0, l2);
            do_req(3, 0, 20'h13, 16'h0, l3);
        join
        for (int k = 0; k < 4; k++) chk("sim_order", q_g.size() > k ? q_g[k] : -1, k);
        if (q_c.size() == 4) for (int k = 1; k < 4; k++) chk("sim_spacing", q_c[k] - q_c[k-1], 4);
        chk("sim_lat0", l0, 3);
        chk("sim_lat3", l3, 15);
        chk("sim_rd0", rdata[0], 16'h1111);
        chk("sim_rd1", rdata[1], 16'h2222);
        chk("sim_rd2", rdata[2], 16'h3333);
        chk("sim_rd3", rdata[3], 16'h4444);

        q_g.delete(); q_c.delete();
        ce_n[0] = 0; we_n[0] = 1; addr[0] = 20'h10;
        ce_n[2] = 0; we_n[2] = 0; addr[2] = 20'h20; wdata[2] = 16'h5A5A;
        repeat (35) @(posedge clk); #1;
        ce_n[0] = 1; ce_n[2] = 1;
        repeat (8) @(posedge clk); #1;
        bad = 0; gap = 0;
        for (int k = 1; k < q_g.size(); k++)
            if (q_g[k] == q_g[k-1] || (q_g[k] != 0 && q_g[k] != 2)) bad++;
        for (int k = 2; k < q_c.size(); k++)
            if (q_c[k] - q_c[k-2] > gap) gap = q_c[k] - q_c[k-2];
        chk("fair_first", q_g.size() > 0 ? q_g[0] : -1, 0);
        chk("fair_enough", q_g.size() >= 8, 1);
        chk("fair_alternate", bad, 0);
        chk("fair_gap", gap, 7);
        chk("fair_mem", mem[11'h020], 16'h5A5A);

        c0 = n_cs;
        do_req(1, 1, 20'h00800, 16'h1234, l1);
        chk("oor_wr_lat", l1, 2);
        chk("oor_err_set", oor_err, 1);
        do_req(1, 0, 20'h00800, 16'h0000, l1);
        chk("oor_rd_lat", l1, 3);
        chk("oor_rdata", rdata[1], 16'h0000);
        chk("oor_no_cs", n_cs - c0, 0);
        chk("oor_no_alias", mem[0], 16'h0000);
        chk("oor_err_sticky", oor_err, 1);

        ce_n[2] = 0; we_n[2] = 0; addr[2] = 20'h12; wdata[2] = 16'hDEAD;
        @(posedge clk); #2 reset = 0;
        #1;
        chk("arst_write", mem_write, 0);
        chk("arst_cs", mem_chipselect, 0);
        chk("arst_ready", rdy, 0);
        chk("arst_addr", mem_address, 0);
        chk("arst_wdata", mem_writedata, 0);
        chk("arst_oor", oor_err, 0);
        for (int i = 0; i < 4; i++) chk("arst_rdata", rdata[i], 0);
        ce_n[2] = 1;
        repeat (2) @(posedge clk); #1 reset = 1;
        chk("arst_mem_kept", mem[11'h012], 16'h3333);
        q_g.delete(); q_c.delete();
        fork
            do_req(1, 0, 20'h13, 16'h0, l1);
            do_req(3, 0, 20'h10, 16'h0, l3);
        join
        chk("arst_first_grant", q_g.size() > 0 ? q_g[0] : -1, 1);
        chk("arst_rd3", rdata[3], 16'h1111);

        ce_n[3] = 0; we_n[3] = 1; addr[3] = 20'h11; t0 = cyc; got = 0; l3 = 0;
        @(posedge clk); #1;
        ce_n[3] = 1; addr[3] = 20'h7FF;
        for (int k = 0; k < 10 && !got; k++) begin
            @(negedge clk);
            if (rdy[3]) begin got = 1; l3 = cyc - t0; end
        end
        chk("early_seen", got, 1);
        chk("early_lat", l3, 3);
        chk("early_rdata", rdata[3], 16'h2222);

        repeat (3) @(posedge clk); #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
